// File: rtl/demux16_deser.sv
// demux16_deser: routes a serial bit stream into 16 lanes under a write
// pointer, assembles a 16-transfer frame and holds it until the consumer
// takes it. Frame length is counted in transfers, not pointer position,
// so explicit lane addressing and pointer wrap never end a frame early.
module demux16_deser (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [3:0]  sel,
  input  logic        sel_load,
  input  logic        inh,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [3:0]  ptr,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [3:0]  ptr_reg, ptr_next;
  logic        valid_reg, valid_next;
  logic        overrun_reg, overrun_next;
  logic [15:0] dout_reg, dout_next;
  logic [15:0] lane_we;
  logic [3:0]  wr_addr;
  logic        xfer;

  // Input is accepted whenever a frame is not being held and not inhibited.
  assign din_ready = (state_reg != HOLD) && !inh;
  assign xfer      = din_valid && din_ready;
  // A coincident pointer load redirects the current write to the loaded lane.
  assign wr_addr   = sel_load ? sel : ptr_reg;

  // One write-enable per lane, decoded from the effective write address.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
      assign lane_we[gi] = xfer && (wr_addr == 4'(gi));
    end
  endgenerate

  // Next-state, counter, pointer and flag logic.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ptr_next     = ptr_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    dout_next    = (dout_reg & ~lane_we) | ({16{din}} & lane_we);

    case (state_reg)
      IDLE: begin
        if (xfer) begin
          cnt_next   = 5'd1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          cnt_next = cnt_reg + 5'd1;
          if (cnt_reg == 5'd15) begin
            state_next = HOLD;
            valid_next = 1'b1;
          end
        end
      end
      HOLD: begin
        if (din_valid && !inh) overrun_next = 1'b1;
        if (dout_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
          cnt_next   = 5'd0;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        cnt_next   = 5'd0;
      end
    endcase

    // Pointer moves only outside HOLD; a transfer advances past the written lane.
    if (state_reg != HOLD) begin
      if (xfer)          ptr_next = wr_addr + 4'd1;
      else if (sel_load) ptr_next = sel;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 5'd0;
      ptr_reg     <= 4'd0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      dout_reg    <= 16'h0000;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      dout_reg    <= dout_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = valid_reg;
  assign ptr        = ptr_reg;
  assign overrun    = overrun_reg;

endmodule
